// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds scan-code prefixes, decoder states and the key-event layout.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } ps2_state_e;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;

   localparam int EVT_W = $bits(ps2_evt_t);

endpackage

// File: rtl/ps2_evt_fifo.sv
// Key-event FIFO with zero-latency head output.
// A write while full is taken only when a pop frees a slot.
module ps2_evt_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_rd;
   logic             do_wr;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_rd   = rd_en & ~empty;
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_wr}
                        - {{AW{1'b0}}, do_rd};
      end
   end

   // Storage is not reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: line sync, 11-bit frame capture,
// E0/F0 prefix decoding and a queue of decoded key events.
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 3,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   input  logic                          rd_en,
   input  logic                          err_clr,
   output logic                          evt_valid,
   output logic [7:0]                    evt_code,
   output logic                          evt_ext,
   output logic                          evt_brk,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          overflow,
   output logic                          frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   strobe;
   logic                   data_s;

   // Idle level is high, so reset to 1 avoids a false edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign strobe = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   logic [9:0]    shreg;
   logic [10:0]   frame;
   logic [3:0]    bit_cnt;
   logic [TW-1:0] to_cnt;
   logic          last_bit;
   logic          frame_good;
   logic          frame_ok;
   logic          frame_bad;
   logic          timeout;
   logic [7:0]    rx_byte;

   assign frame      = {data_s, shreg};
   assign last_bit   = strobe && (bit_cnt == 4'd10);
   assign frame_good = ~frame[0] & frame[10] & (^frame[9:1]);
   assign frame_ok   = last_bit & frame_good;
   assign frame_bad  = last_bit & ~frame_good;
   assign rx_byte    = frame[8:1];
   assign timeout    = ~strobe && (bit_cnt != 4'd0)
                    && (to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '1;
         bit_cnt <= '0;
         to_cnt  <= '0;
      end else if (strobe) begin
         shreg   <= {data_s, shreg[9:1]};
         bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
         to_cnt  <= '0;
      end else if (timeout) begin
         bit_cnt <= '0;
         to_cnt  <= '0;
      end else if (bit_cnt != 4'd0) begin
         to_cnt  <= to_cnt + 1'b1;
      end else begin
         to_cnt  <= '0;
      end
   end

   ps2_state_e state;
   ps2_state_e state_nxt;
   ps2_evt_t   evt;
   logic       push;

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      evt       = '0;
      if (frame_ok) begin
         if (rx_byte == PS2_EXT) begin
            if (state == ST_IDLE) state_nxt = ST_EXT;
         end else if (rx_byte == PS2_BRK) begin
            unique case (state)
               ST_IDLE:    state_nxt = ST_BRK;
               ST_EXT:     state_nxt = ST_EXT_BRK;
               ST_BRK:     state_nxt = ST_BRK;
               ST_EXT_BRK: state_nxt = ST_EXT_BRK;
            endcase
         end else begin
            push      = 1'b1;
            evt.ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
            evt.brk   = (state == ST_BRK) || (state == ST_EXT_BRK);
            evt.code  = rx_byte;
            state_nxt = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   ps2_evt_t head;
   logic     empty;
   logic     full;
   logic     ovf_set;
   logic     ferr_set;

   ps2_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (evt),
      .rd_en   (rd_en),
      .rd_data (head),
      .empty   (empty),
      .full    (full),
      .count   (evt_count)
   );

   assign evt_valid = ~empty;
   assign evt_code  = head.code;
   assign evt_ext   = head.ext;
   assign evt_brk   = head.brk;

   // A set in the same cycle as err_clr wins.
   assign ovf_set  = push & full & ~(rd_en & ~empty);
   assign ferr_set = frame_bad | timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overflow  <= ovf_set  | (overflow  & ~err_clr);
         frame_err <= ferr_set | (frame_err & ~err_clr);
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: drives PS/2 frames,
// models prefix decoding and checks popped events in order.
module tb_ps2_keyboard_rx;

   localparam int DEPTH = 8;
   localparam int SYNC  = 3;
   localparam int TOUT  = 500;
   localparam int HP    = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic          ps2_clk;
   logic          ps2_data;
   logic          rd_en;
   logic          err_clr;
   logic          evt_valid;
   logic [7:0]    evt_code;
   logic          evt_ext;
   logic          evt_brk;
   logic [CW-1:0] evt_count;
   logic          overflow;
   logic          frame_err;

   ps2_keyboard_rx #(
      .FIFO_DEPTH  (DEPTH),
      .SYNC_STAGES (SYNC),
      .TIMEOUT_CYC (TOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rd_en     (rd_en),
      .err_clr   (err_clr),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .evt_ext   (evt_ext),
      .evt_brk   (evt_brk),
      .evt_count (evt_count),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [9:0] sb[$];
   logic [1:0] m_state = 2'd0;
   bit         exp_ovf = 1'b0;

   // Drives nbits of a frame; optionally pops on the stop-bit write edge.
   task automatic send_frame(input logic [7:0] b, input bit bad,
                             input int nbits, input bit pop_stop);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         repeat (HP) @(negedge clk);
         ps2_clk = 1'b0;
         if (pop_stop && i == 10) begin
            repeat (SYNC) @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            repeat (HP - SYNC - 1) @(negedge clk);
         end else begin
            repeat (HP) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (2 * HP) @(negedge clk);
   endtask

   task automatic model_byte(input logic [7:0] b, input bit pop_same);
      if (b == 8'hE0) begin
         if (m_state == 2'd0) m_state = 2'd1;
      end else if (b == 8'hF0) begin
         if (m_state == 2'd0)      m_state = 2'd2;
         else if (m_state == 2'd1) m_state = 2'd3;
      end else begin
         if (pop_same) begin
            void'(sb.pop_front());
            sb.push_back({m_state[0], m_state[1], b});
         end else if (sb.size() < DEPTH) begin
            sb.push_back({m_state[0], m_state[1], b});
         end else begin
            exp_ovf = 1'b1;
         end
         m_state = 2'd0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 11, 1'b0);
      model_byte(b, 1'b0);
   endtask

   task automatic pop_event(output logic [9:0] ev, output bit got);
      got = 1'b0;
      ev  = '0;
      for (int i = 0; i < 50 && !got; i++) begin
         if (evt_valid) got = 1'b1;
         else @(negedge clk);
      end
      if (got) begin
         ev = {evt_ext, evt_brk, evt_code};
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
      end
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (evt_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_valid got %b want 0", evt_valid);
      end
      n_cmp++;
      if (evt_count !== '0) begin
         n_bad++;
         $display("FAIL rst_count got %0d want 0", evt_count);
      end
      n_cmp++;
      if (overflow !== 1'b0 || frame_err !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_flags got %b%b want 00",
                  overflow, frame_err);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_make();
      logic [9:0] ev;
      logic [9:0] exp;
      bit got;
      send_byte(8'h1C);
      n_cmp++;
      if (evt_valid !== 1'b1 || evt_count !== CW'(sb.size())) begin
         n_bad++;
         $display("FAIL make_valid got v=%b n=%0d want v=1 n=%0d",
                  evt_valid, evt_count, sb.size());
      end
      pop_event(ev, got);
      exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
      n_cmp++;
      if (!got || ev !== exp) begin
         n_bad++;
         $display("FAIL make_evt got %h want %h", ev, exp);
      end
      n_cmp++;
      if (evt_count !== '0) begin
         n_bad++;
         $display("FAIL make_drain got %0d want 0", evt_count);
      end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      n_cmp++;
      if (evt_count !== '0 || evt_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL empty_rd got n=%0d v=%b want 0 0",
                  evt_count, evt_valid);
      end
   endtask

   task automatic test_prefix();
      logic [9:0] ev;
      logic [9:0] exp;
      bit got;
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      n_cmp++;
      if (evt_count !== 1) begin
         n_bad++;
         $display("FAIL pfx_count got %0d want 1", evt_count);
      end
      send_byte(8'hE0);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'hF0);
      send_byte(8'h74);
      send_byte(8'hF0);
      send_byte(8'hE0);
      send_byte(8'h14);
      send_byte(8'hE0);
      send_byte(8'h6B);
      for (int i = 0; i < 4; i++) begin
         pop_event(ev, got);
         exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
         n_cmp++;
         if (!got || ev !== exp) begin
            n_bad++;
            $display("FAIL pfx_evt%0d got %h want %h", i, ev, exp);
         end
      end
   endtask

   task automatic test_parity();
      send_frame(8'h1C, 1'b1, 11, 1'b0);
      n_cmp++;
      if (evt_valid !== 1'b0 || frame_err !== 1'b1) begin
         n_bad++;
         $display("FAIL par_err got v=%b e=%b want v=0 e=1",
                  evt_valid, frame_err);
      end
      pulse_clr();
      n_cmp++;
      if (frame_err !== 1'b0) begin
         n_bad++;
         $display("FAIL par_clr got %b want 0", frame_err);
      end
   endtask

   task automatic test_timeout();
      logic [9:0] ev;
      logic [9:0] exp;
      bit got;
      send_frame(8'hAA, 1'b0, 6, 1'b0);
      repeat (TOUT + 1) @(negedge clk);
      send_byte(8'h32);
      n_cmp++;
      if (frame_err !== 1'b1 || evt_count !== 1) begin
         n_bad++;
         $display("FAIL tout_state got e=%b n=%0d want e=1 n=1",
                  frame_err, evt_count);
      end
      pop_event(ev, got);
      exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
      n_cmp++;
      if (!got || ev !== exp) begin
         n_bad++;
         $display("FAIL tout_evt got %h want %h", ev, exp);
      end
      pulse_clr();
   endtask

   task automatic test_overflow();
      logic [9:0] ev;
      logic [9:0] exp;
      bit got;
      exp_ovf = 1'b0;
      for (int i = 1; i <= DEPTH + 1; i++) send_byte(8'(i));
      n_cmp++;
      if (evt_count !== CW'(DEPTH) || overflow !== exp_ovf) begin
         n_bad++;
         $display("FAIL ovf_state got n=%0d o=%b want n=%0d o=%b",
                  evt_count, overflow, DEPTH, exp_ovf);
      end
      for (int i = 0; i < DEPTH; i++) begin
         pop_event(ev, got);
         exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
         n_cmp++;
         if (!got || ev !== exp) begin
            n_bad++;
            $display("FAIL ovf_pop%0d got %h want %h", i, ev, exp);
         end
      end
      pulse_clr();
      n_cmp++;
      if (overflow !== 1'b0 || evt_count !== '0) begin
         n_bad++;
         $display("FAIL ovf_clr got o=%b n=%0d want 0 0",
                  overflow, evt_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] ev;
      logic [9:0] exp;
      bit got;
      for (int i = 0; i < DEPTH; i++) send_byte(8'h11 + 8'(i));
      send_frame(8'h19, 1'b0, 11, 1'b1);
      model_byte(8'h19, 1'b1);
      n_cmp++;
      if (evt_count !== CW'(DEPTH) || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_state got n=%0d o=%b want n=%0d o=0",
                  evt_count, overflow, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         pop_event(ev, got);
         exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
         n_cmp++;
         if (!got || ev !== exp) begin
            n_bad++;
            $display("FAIL b2b_pop%0d got %h want %h", i, ev, exp);
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [9:0] ev;
      logic [9:0] exp;
      bit got;
      send_byte(8'h33);
      send_frame(8'h1C, 1'b1, 11, 1'b0);
      send_byte(8'hE0);
      send_frame(8'h1C, 1'b0, 5, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      m_state = 2'd0;
      n_cmp++;
      if (evt_valid !== 1'b0 || evt_count !== '0) begin
         n_bad++;
         $display("FAIL mrst_fifo got v=%b n=%0d want 0 0",
                  evt_valid, evt_count);
      end
      n_cmp++;
      if (overflow !== 1'b0 || frame_err !== 1'b0) begin
         n_bad++;
         $display("FAIL mrst_flags got %b%b want 00",
                  overflow, frame_err);
      end
      repeat (4) @(negedge clk);
      send_byte(8'h1C);
      pop_event(ev, got);
      exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
      n_cmp++;
      if (!got || ev !== exp) begin
         n_bad++;
         $display("FAIL mrst_evt got %h want %h", ev, exp);
      end
      n_cmp++;
      if (frame_err !== 1'b0 || evt_count !== '0) begin
         n_bad++;
         $display("FAIL mrst_after got e=%b n=%0d want 0 0",
                  frame_err, evt_count);
      end
   endtask

   initial begin
      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rd_en    = 1'b0;
      err_clr  = 1'b0;
      @(negedge clk);
      test_reset();
      test_make();
      test_prefix();
      test_parity();
      test_timeout();
      test_overflow();
      test_back_to_back();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
